// File: rtl/ads8681_pkg.sv
// Shared definitions for the ADS8681 acquisition controller: FSM encoding,
// command opcodes and register addresses.
package ads8681_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRIG  = 3'd1,
      ST_CONV  = 3'd2,
      ST_XFER  = 3'd3,
      ST_QUIET = 3'd4
   } acq_state_t;

   localparam int CNT_W = 16;

   localparam logic [6:0] OP_NOP        = 7'b0000000;
   localparam logic [6:0] OP_WRITE      = 7'b1101000;
   localparam logic [6:0] OP_READ_HWORD = 7'b1100100;

   localparam logic [8:0] REG_RANGE_SEL   = 9'h014;
   localparam logic [8:0] REG_DATAOUT_CTL = 9'h010;

   // 32-bit SDI command: opcode, register address, 16-bit payload.
   function automatic logic [31:0] make_cmd(input logic [6:0] op,
                                            input logic [8:0] addr,
                                            input logic [15:0] data);
      return {op, addr, data};
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles sclk every CLK_DIV cycles while enabled, idles low.
// rise/fall flag the cycle whose closing edge makes the registered sclk change.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick = en && (div_cnt == DIV_LAST);
   assign rise = tick && !sclk;
   assign fall = tick && sclk;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         sclk    <= !sclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ads8681_spi_acq.sv
// ADS8681 acquisition controller: trigger a conversion with a cs_n pulse, wait
// out the conversion, then run one SPI-00 frame reading SDO and writing SDI.
module ads8681_spi_acq
   import ads8681_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int CS_PULSE     = 2,
   parameter int CONV_CYCLES  = 40,
   parameter int QUIET_CYCLES = 4,
   parameter int FRAME_BITS   = 32
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] cmd_word,
   output logic        busy,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        cs_n,
   output logic        sclk,
   output logic        sdi,
   input  logic        sdo,
   output logic [2:0]  dbg_state
);

   localparam logic [CNT_W-1:0] CS_LAST    = CNT_W'(CS_PULSE - 1);
   localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
   localparam logic [5:0]       BIT_LAST   = 6'(FRAME_BITS - 1);
   localparam logic [31:0]      FRAME_MASK = (FRAME_BITS == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;

   acq_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [5:0]       bit_cnt;
   logic [31:0]      tx, rx;
   logic             sclk_rise, sclk_fall;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .en     (state == ST_XFER),
      .sclk   (sclk),
      .rise   (sclk_rise),
      .fall   (sclk_fall)
   );

   assign dbg_state = state;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (start) state_n = ST_TRIG;
         end
         ST_TRIG: begin
            if (cnt == CS_LAST) begin
               state_n = ST_CONV;
               cnt_n   = '0;
            end
         end
         ST_CONV: begin
            if (cnt == CONV_LAST) begin
               state_n = ST_XFER;
               cnt_n   = '0;
            end
         end
         ST_XFER: begin
            // The falling edge after the last sampled bit closes the frame.
            cnt_n = '0;
            if (sclk_fall && bit_cnt == BIT_LAST) state_n = ST_QUIET;
         end
         ST_QUIET: begin
            if (cnt == QUIET_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cs_n       <= 1'b1;
         sdi        <= 1'b0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         data_out   <= '0;
         bit_cnt    <= '0;
         tx         <= '0;
         rx         <= '0;
      end else begin
         cs_n       <= !(state_n == ST_TRIG || state_n == ST_XFER);
         busy       <= (state_n != ST_IDLE);
         data_valid <= (state == ST_XFER) && (state_n == ST_QUIET);

         if (state == ST_IDLE && start) begin
            tx      <= cmd_word;
            rx      <= '0;
            bit_cnt <= '0;
         end

         if (state == ST_XFER) begin
            if (sclk_rise) rx <= {rx[30:0], sdo};
            if (sclk_fall) begin
               tx <= {tx[30:0], 1'b0};
               if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
            end
         end

         // bit_cnt is the index of the bit currently on the wire.
         if (state == ST_CONV && state_n == ST_XFER) begin
            sdi <= tx[31];
         end else if (state_n == ST_QUIET) begin
            sdi <= 1'b0;
         end else if (state == ST_XFER && sclk_fall) begin
            sdi <= tx[30];
         end

         if (state == ST_XFER && state_n == ST_QUIET) data_out <= rx & FRAME_MASK;
      end
   end

endmodule

// File: tb/tb_ads8681_spi_acq.sv
// Four controller instances (default, 16-bit frame, CLK_DIV=1, CLK_DIV=7) share one
// start/cmd stream; each has its own ADC SDO model, frame monitor and reference queue.
module tb_ads8681_spi_acq;
   import ads8681_pkg::*;

   localparam int NI = 4;
   localparam logic [31:0] DIV_P = {8'd7, 8'd1, 8'd4, 8'd4};
   localparam logic [31:0] FB_P  = {8'd32, 8'd32, 8'd16, 8'd32};
   localparam int CS_P    = 2;
   localparam int CONV_P  = 40;
   localparam int QUIET_P = 4;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [31:0] cmd;
   } exp_t;

   logic          clk_in   = 1'b0;
   logic          rst_n    = 1'b1;
   logic          start    = 1'b0;
   logic [31:0]   cmd_word = '0;
   logic [NI-1:0] busy_v;
   int            cyc      = 0;
   int            n_checks = 0;
   int            n_fail   = 0;
   event          done_ev;

   // clock / reset
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   task automatic check(input int inst, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL i%0d %s: got %h, expected %h (cycle %0d)", inst, name, act, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic issue(input logic [31:0] cmd);
      @(posedge clk_in);
      #1 start = 1'b1;
      cmd_word = cmd;
      @(posedge clk_in);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy_v != '0 && n < budget) begin
         @(posedge clk_in);
         n++;
      end
      n_checks++;
      if (busy_v != '0) begin
         n_fail++;
         $display("FAIL wait_idle: busy %b after %0d cycles, expected 0", busy_v, budget);
      end
      repeat (3) @(posedge clk_in);
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DIV  = int'(DIV_P[g*8 +: 8]);
      localparam int FB   = int'(FB_P[g*8 +: 8]);
      localparam int LAT  = 1 + CS_P + CONV_P + 2 * DIV * FB;
      localparam int SPAN = LAT + QUIET_P;
      localparam logic [31:0] MASK = (FB == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;

      logic        busy, data_valid, cs_n, sclk, sdi, sdo;
      logic [31:0] data_out;
      logic [2:0]  dbg_state;
      exp_t        exp_q[$];
      exp_t        e;
      logic [31:0] sdo_word = '0;
      logic [31:0] sdi_cap  = '0;
      int          sdo_idx = 0, rises = 0, nf = 0, free_at = 0, acc_at = -1;
      int          ph = 0, cs_run = 0, sclk_run = 0;
      logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_dv = 1'b0;

      ads8681_spi_acq #(
         .CLK_DIV      (DIV),
         .CS_PULSE     (CS_P),
         .CONV_CYCLES  (CONV_P),
         .QUIET_CYCLES (QUIET_P),
         .FRAME_BITS   (FB)
      ) dut (
         .clk_in     (clk_in),
         .rst_n      (rst_n),
         .start      (start),
         .cmd_word   (cmd_word),
         .busy       (busy),
         .data_out   (data_out),
         .data_valid (data_valid),
         .cs_n       (cs_n),
         .sclk       (sclk),
         .sdi        (sdi),
         .sdo        (sdo),
         .dbg_state  (dbg_state)
      );

      assign busy_v[g] = busy;
      // ADC presents the MSB after cs_n falls and the next bit after each SCLK fall.
      assign sdo = (sdo_idx < FB) ? sdo_word[FB - 1 - sdo_idx] : 1'b0;

      always @(negedge rst_n) begin
         #1;
         check(g, "rst_cs_n", cs_n, 1'b1);
         check(g, "rst_sclk", sclk, 1'b0);
         check(g, "rst_sdi", sdi, 1'b0);
         check(g, "rst_busy", busy, 1'b0);
         check(g, "rst_data_valid", data_valid, 1'b0);
         check(g, "rst_data_out", data_out, 32'h0);
         check(g, "rst_state", dbg_state, ST_IDLE);
      end

      // monitor + scoreboard + reference model
      always @(negedge clk_in) begin
         if (!rst_n) begin
            exp_q.delete();
            free_at = 0; acc_at = -1; ph = 0; cs_run = 0; sclk_run = 0;
            sdo_idx = 0; rises = 0;
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_dv = 1'b0;
         end else begin
            check(g, "busy", busy, (cyc > acc_at && cyc < free_at));
            if (cs_n) check(g, "sclk_idle_low", sclk, 1'b0);

            if (ph == 3) begin
               if (sclk != prev_sclk) begin
                  check(g, "sclk_half_period", sclk_run, DIV);
                  sclk_run = 1;
                  if (sclk) begin
                     rises++;
                     sdi_cap = {sdi_cap[30:0], sdi};
                  end else begin
                     sdo_idx++;
                  end
               end else begin
                  sclk_run++;
               end
            end

            // cs_n segments: low TRIG, high CONV, low XFER, high QUIET/idle
            if (cs_n == prev_cs) begin
               cs_run++;
            end else begin
               if (!cs_n) begin
                  if (ph == 2) begin
                     check(g, "conv_len", cs_run, CONV_P);
                     ph = 3; sclk_run = 1; sdo_idx = 0; rises = 0; sdi_cap = '0;
                  end else begin
                     if (ph == 4) check(g, "gap_len_ok", cs_run >= QUIET_P + 1, 1'b1);
                     ph = 1;
                  end
               end else begin
                  if (ph == 1) begin
                     check(g, "trig_len", cs_run, CS_P);
                     ph = 2;
                  end else if (ph == 3) begin
                     check(g, "xfer_len", cs_run, 2 * DIV * FB);
                     ph = 4;
                  end else begin
                     check(g, "cs_sequence", ph, 32'hFFFF_FFFF);
                  end
               end
               cs_run = 1;
            end

            if (data_valid) begin
               check(g, "dv_width", prev_dv, 1'b0);
               check(g, "dv_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check(g, "dv_cycle", cyc, e.cyc);
                  check(g, "data_out", data_out, e.data);
                  check(g, "sclk_rises", rises, FB);
                  check(g, "sdi_word", sdi_cap & MASK, e.cmd >> (32 - FB));
               end
            end

            if (start && cyc >= free_at) begin
               acc_at   = cyc;
               free_at  = cyc + SPAN;
               if (nf < 2) sdo_word = (FB == 16) ? 32'h0000_8001 : 32'hA5C3_0F12;
               else        sdo_word = $urandom();
               e.cyc  = cyc + LAT;
               e.data = sdo_word & MASK;
               e.cmd  = cmd_word;
               exp_q.push_back(e);
               nf++;
            end

            prev_cs = cs_n; prev_sclk = sclk; prev_dv = data_valid;
         end
      end

      always @(done_ev) check(g, "queue_empty", exp_q.size(), 0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk_in);
      #1 rst_n = 1'b1;

      issue(make_cmd(OP_WRITE, REG_RANGE_SEL, 16'h0003));
      wait_idle(1000);
      issue(32'h1234_ABCD);
      wait_idle(1000);

      // reset around bit 10 of the default-timing frame
      issue($urandom());
      repeat (125) @(posedge clk_in);
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk_in);
      #1 rst_n = 1'b1;
      issue(make_cmd(OP_READ_HWORD, REG_DATAOUT_CTL, 16'h0000));
      wait_idle(1000);

      for (int i = 0; i < 1000; i++) begin
         @(posedge clk_in);
         #1 start = 1'b1;
         cmd_word = $urandom();
      end
      @(posedge clk_in);
      #1 start = 1'b0;
      wait_idle(1000);

      for (int i = 0; i < 800; i++) begin
         @(posedge clk_in);
         #1 start = ($urandom_range(0, 7) == 0);
         cmd_word = $urandom();
      end
      @(posedge clk_in);
      #1 start = 1'b0;
      wait_idle(1000);

      -> done_ev;
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
